// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : RV32I multi-cycle control FSM (FETCH/DECODE/EXECUTE/MEMORY/WB)
//            with variable-latency memory handshake, retire counter and
//            bus-error watchdog. Define ILLEGAL_TRAP_EN to trap on illegal
//            opcodes and watchdog expiry instead of recovering.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instruction,
    input  logic             comparison,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mux_pc_signal,
    output logic             mux_imm_signal,
    output logic             mux_writedata_register,
    output logic             mux_jalr,
    output logic             read_mem,
    output logic             write_mem,
    output logic             write_register,
    output logic             bus_error,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_retired,
    output logic [2:0]       state
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit C_TRAP = 1'b1;
`else
    localparam bit C_TRAP = 1'b0;
`endif

    localparam int C_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0] C_OP_R      = 7'b0110011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_IARITH = 7'b0010011;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    state_t              r_state;
    logic [6:0]          r_opcode;
    logic                r_illegal;
    logic                r_illegal_pulse;
    logic                r_bus_error;
    logic [C_WD_W-1:0]   r_wd_cnt;
    logic [CNT_W-1:0]    r_retired;

    function automatic logic f_legal(input logic [6:0] op);
        case (op)
            C_OP_R, C_OP_LOAD, C_OP_IARITH, C_OP_JALR,
            C_OP_STORE, C_OP_BRANCH, C_OP_LUI, C_OP_JAL: f_legal = 1'b1;
            default:                                     f_legal = 1'b0;
        endcase
    endfunction

    logic w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_uses_imm;
    assign w_is_load   = (r_opcode == C_OP_LOAD);
    assign w_is_store  = (r_opcode == C_OP_STORE);
    assign w_is_branch = (r_opcode == C_OP_BRANCH);
    assign w_is_jal    = (r_opcode == C_OP_JAL);
    assign w_is_jalr   = (r_opcode == C_OP_JALR);
    assign w_uses_imm  = w_is_load | w_is_store | w_is_jalr |
                         (r_opcode == C_OP_IARITH) | (r_opcode == C_OP_LUI);

    // Watchdog only runs while stalled on a memory handshake; a ready in the
    // expiry cycle suppresses the error.
    logic w_waiting, w_ready, w_expire;
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMORY);
    assign w_ready   = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    assign w_expire  = (TIMEOUT != 0) && w_waiting && !w_ready &&
                       (r_wd_cnt == C_WD_W'(TIMEOUT - 1));

    logic w_imem_req, w_ir_write, w_pc_write, w_mux_pc, w_mux_imm, w_mux_wd;
    logic w_mux_jalr, w_read_mem, w_write_mem, w_write_reg, w_retire;

    always_comb begin
        w_imem_req  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_mux_pc    = 1'b0;
        w_mux_imm   = 1'b0;
        w_mux_wd    = 1'b0;
        w_mux_jalr  = 1'b0;
        w_read_mem  = 1'b0;
        w_write_mem = 1'b0;
        w_write_reg = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                w_ir_write = imem_ready;
            end
            S_EXECUTE: begin
                w_mux_imm = w_uses_imm;
                if (r_illegal) begin
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                end else if (w_is_branch) begin
                    w_pc_write = 1'b1;
                    w_mux_pc   = comparison;
                    w_retire   = 1'b1;
                end
            end
            S_MEMORY: begin
                w_read_mem  = w_is_load;
                w_write_mem = w_is_store;
                w_mux_imm   = 1'b1;
                if (dmem_ready && w_is_store) begin
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                end else if (w_expire && !C_TRAP) begin
                    w_pc_write = 1'b1;
                end
            end
            S_WRITEBACK: begin
                w_write_reg = 1'b1;
                w_pc_write  = 1'b1;
                w_retire    = 1'b1;
                w_mux_wd    = w_is_load;
                w_mux_pc    = w_is_jal | w_is_jalr;
                w_mux_jalr  = w_is_jalr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_FETCH;
            r_opcode        <= 7'd0;
            r_illegal       <= 1'b0;
            r_illegal_pulse <= 1'b0;
            r_bus_error     <= 1'b0;
            r_wd_cnt        <= '0;
            r_retired       <= '0;
        end else begin
            r_illegal_pulse <= 1'b0;
            if (w_retire)
                r_retired <= r_retired + 1'b1;
            if (w_expire)
                r_bus_error <= 1'b1;
            if (w_waiting && !w_ready && !w_expire)
                r_wd_cnt <= r_wd_cnt + 1'b1;
            else
                r_wd_cnt <= '0;

            case (r_state)
                S_FETCH: begin
                    if (imem_ready)
                        r_state <= S_DECODE;
                    else if (w_expire)
                        r_state <= C_TRAP ? S_TRAP : S_FETCH;
                end
                S_DECODE: begin
                    r_opcode        <= instruction[6:0];
                    r_illegal       <= !f_legal(instruction[6:0]);
                    r_illegal_pulse <= !f_legal(instruction[6:0]);
                    r_state <= (C_TRAP && !f_legal(instruction[6:0])) ? S_TRAP : S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (r_illegal || w_is_branch)
                        r_state <= S_FETCH;
                    else if (w_is_load || w_is_store)
                        r_state <= S_MEMORY;
                    else
                        r_state <= S_WRITEBACK;
                end
                S_MEMORY: begin
                    if (dmem_ready)
                        r_state <= w_is_load ? S_WRITEBACK : S_FETCH;
                    else if (w_expire)
                        r_state <= C_TRAP ? S_TRAP : S_FETCH;
                end
                S_WRITEBACK: r_state <= S_FETCH;
                S_TRAP:      r_state <= S_TRAP;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Strobes are forced low the instant rst_n falls, including the FETCH request.
    assign imem_req               = rst_n & w_imem_req;
    assign ir_write               = rst_n & w_ir_write;
    assign pc_write               = rst_n & w_pc_write;
    assign mux_pc_signal          = rst_n & w_mux_pc;
    assign mux_imm_signal         = rst_n & w_mux_imm;
    assign mux_writedata_register = rst_n & w_mux_wd;
    assign mux_jalr               = rst_n & w_mux_jalr;
    assign read_mem               = rst_n & w_read_mem;
    assign write_mem              = rst_n & w_write_mem;
    assign write_register         = rst_n & w_write_reg;
    assign bus_error              = r_bus_error;
    assign illegal_instr          = r_illegal_pulse;
    assign instr_retired          = r_retired;
    assign state                  = r_state;

    logic w_unused;
    assign w_unused = ^instruction;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control: vector table, random
//            instruction stream against a trace model, timeout/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int K_R = 0, K_LOAD = 1, K_IAR = 2, K_JALR = 3, K_STORE = 4,
                   K_BR = 5, K_LUI = 6, K_JAL = 7, K_ILL = 8;

    logic clk, rst_n, comparison, imem_ready, dmem_ready;
    logic [31:0] instruction;
    logic imem_req, ir_write, pc_write, mux_pc_signal, mux_imm_signal;
    logic mux_writedata_register, mux_jalr, read_mem, write_mem, write_register;
    logic bus_error, illegal_instr;
    logic [CNT_W-1:0] instr_retired;
    logic [2:0] state;

    multicycle_control #(.WIDTH(32), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .comparison(comparison),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .mux_pc_signal(mux_pc_signal),
        .mux_imm_signal(mux_imm_signal), .mux_writedata_register(mux_writedata_register),
        .mux_jalr(mux_jalr), .read_mem(read_mem), .write_mem(write_mem),
        .write_register(write_register), .bus_error(bus_error),
        .illegal_instr(illegal_instr), .instr_retired(instr_retired), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic imem_req, ir_write, pc_write, mux_pc, mux_imm, mux_wd, mux_jalr,
              read_mem, write_mem, write_reg;
    } strobes_t;

    typedef struct {
        logic [2:0] st;
        strobes_t   sb;
        bit         ir, dr, ill, be;
    } cyc_t;

    typedef struct {
        logic [31:0] ins;
        bit          cmp;
        int          iwait, dwait;
        int          exp_wreg, exp_pcw;
        string       name;
    } vec_t;

    cyc_t tq[$];
    vec_t vecs[$];
    int   total = 0, bad = 0;
    int   m_ret = 0;
    bit   m_berr = 1'b0;
    int   n_wreg, n_pcw;

    function automatic strobes_t dut_sb();
        return {imem_req, ir_write, pc_write, mux_pc_signal, mux_imm_signal,
                mux_writedata_register, mux_jalr, read_mem, write_mem, write_register};
    endfunction

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0000011: return K_LOAD;
            7'b0010011: return K_IAR;
            7'b1100111: return K_JALR;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            7'b0110111: return K_LUI;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input strobes_t sb, input bit ir, input bit dr, input bit ill);
        cyc_t c;
        c.st = st; c.sb = sb; c.ir = ir; c.dr = dr; c.ill = ill; c.be = m_berr;
        tq.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction, straight from the
    // instruction-class rules; MEMORY waits are kept below the watchdog limit.
    task automatic build_trace(input logic [31:0] ins, input bit cmp, input int iwait, input int dwait);
        strobes_t s;
        int c;
        c = cls_of(ins[6:0]);
        tq.delete();
        for (int k = 1; k <= iwait; k++) begin
            s = '0; s.imem_req = 1'b1;
            push(3'd0, s, 1'b0, 1'b0, 1'b0);
            if (k % TIMEOUT == 0) m_berr = 1'b1;
        end
        s = '0; s.imem_req = 1'b1; s.ir_write = 1'b1;
        push(3'd0, s, 1'b1, 1'b0, 1'b0);
        s = '0;
        push(3'd1, s, 1'b0, 1'b0, 1'b0);
        s = '0;
        s.mux_imm = (c == K_LOAD) || (c == K_IAR) || (c == K_JALR) || (c == K_STORE) || (c == K_LUI);
        if (c == K_BR) begin s.pc_write = 1'b1; s.mux_pc = cmp; end
        if (c == K_ILL) s.pc_write = 1'b1;
        push(3'd2, s, 1'b0, 1'b0, c == K_ILL);
        if (c == K_BR || c == K_ILL) begin m_ret++; return; end
        if (c == K_LOAD || c == K_STORE) begin
            for (int k = 0; k <= dwait; k++) begin
                s = '0; s.mux_imm = 1'b1;
                s.read_mem = (c == K_LOAD); s.write_mem = (c == K_STORE);
                s.pc_write = (c == K_STORE) && (k == dwait);
                push(3'd3, s, 1'b0, k == dwait, 1'b0);
            end
            if (c == K_STORE) begin m_ret++; return; end
        end
        s = '0; s.write_reg = 1'b1; s.pc_write = 1'b1;
        s.mux_wd = (c == K_LOAD); s.mux_pc = (c == K_JAL) || (c == K_JALR); s.mux_jalr = (c == K_JALR);
        push(3'd4, s, 1'b0, 1'b0, 1'b0);
        m_ret++;
    endtask

    task automatic play_trace(input string name);
        logic [14:0] got, want;
        n_wreg = 0; n_pcw = 0;
        foreach (tq[i]) begin
            imem_ready = tq[i].ir;
            dmem_ready = tq[i].dr;
            @(negedge clk);
            got  = {state, dut_sb(), illegal_instr, bus_error};
            want = {tq[i].st, tq[i].sb, tq[i].ill, tq[i].be};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s cyc%0d: got st=%0d sb=%b ill=%b be=%b want st=%0d sb=%b ill=%b be=%b",
                         name, i, got[14:12], got[11:2], got[1], got[0],
                         want[14:12], want[11:2], want[1], want[0]);
            end
            n_wreg += int'(write_register);
            n_pcw  += int'(pc_write);
            cycle();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        chk({name, " retired"}, 32'(instr_retired), 32'(m_ret % (1 << CNT_W)));
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; comparison = 1'b1;
        @(negedge clk);
        chk({name, " outputs"}, {dut_sb(), bus_error, illegal_instr, state, instr_retired}, 32'd0);
        m_ret = 0; m_berr = 1'b0;
        cycle();
        rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; comparison = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        instruction = v.ins;
        comparison  = v.cmp;
        build_trace(v.ins, v.cmp, v.iwait, v.dwait);
        play_trace(v.name);
        chk({v.name, " wreg cycles"}, 32'(n_wreg), 32'(v.exp_wreg));
        chk({v.name, " pcw cycles"}, 32'(n_pcw), 32'(v.exp_pcw));
    endtask

    logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111,
                                   7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};
    logic [6:0] bad_ops   [3] = '{7'b0000000, 7'b1111111, 7'b0010111};

    initial begin
        rst_n = 1'b0; instruction = 32'd0; comparison = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("reset");
        @(negedge clk);
        chk("first imem_req", 32'(imem_req), 32'd1);
        cycle();
        do_reset("reset2");

        vecs.push_back('{32'h002081B3, 1'b0, 1,  0,  1, 1, "add"});
        vecs.push_back('{32'h0000A183, 1'b0, 0,  3,  1, 1, "lw d3"});
        vecs.push_back('{32'h00208463, 1'b1, 0,  0,  0, 1, "beq taken"});
        vecs.push_back('{32'h00208463, 1'b0, 0,  0,  0, 1, "beq not"});
        vecs.push_back('{32'h000080E7, 1'b0, 2,  0,  1, 1, "jalr"});
        vecs.push_back('{32'h0020A023, 1'b0, 0,  2,  0, 1, "sw d2"});
        vecs.push_back('{32'h00108093, 1'b0, 0,  0,  1, 1, "addi"});
        vecs.push_back('{32'h000010B7, 1'b0, 0,  0,  1, 1, "lui"});
        vecs.push_back('{32'h008000EF, 1'b0, 0,  0,  1, 1, "jal"});
        vecs.push_back('{32'h0000A183, 1'b0, 0, 15,  1, 1, "lw ready at expiry"});
        vecs.push_back('{32'h002081B3, 1'b0, 15, 0,  1, 1, "add fetch ready at expiry"});
        vecs.push_back('{32'h0020A023, 1'b0, 0,  0,  0, 1, "sw d0"});
`ifndef ILLEGAL_TRAP_EN
        vecs.push_back('{32'h00000000, 1'b0, 0,  0,  0, 1, "illegal nop"});
`endif
        foreach (vecs[i]) run_vec(vecs[i]);
        chk("no spurious bus_error", 32'(bus_error), 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] r;
            logic [6:0]  op;
            vec_t v;
            r  = $urandom;
            op = legal_ops[$urandom_range(0, 7)];
            if (!TRAP && $urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 2)];
            v.ins = {r[31:7], op};
            v.cmp = 1'($urandom_range(0, 1));
            v.iwait = $urandom_range(0, 12);
            v.dwait = $urandom_range(0, 12);
            instruction = v.ins;
            comparison  = v.cmp;
            build_trace(v.ins, v.cmp, v.iwait, v.dwait);
            play_trace("rnd");
        end

        // Store whose data memory never answers.
        do_reset("reset3");
        instruction = 32'h0020A023; imem_ready = 1'b1;
        cycle(); imem_ready = 1'b0;
        cycle(); cycle();
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 1 || k == TIMEOUT) begin
                chk("memwait write_mem", 32'(write_mem), 32'd1);
                chk("memwait no berr", 32'(bus_error), 32'd0);
            end
            if (k == TIMEOUT) chk("expiry pc_write", 32'(pc_write), 32'(!TRAP));
            cycle();
        end
        chk("timeout bus_error", 32'(bus_error), 32'd1);
        chk("timeout write_mem drop", 32'(write_mem), 32'd0);
        chk("timeout state", 32'(state), TRAP ? 32'd5 : 32'd0);
        chk("timeout no retire", 32'(instr_retired), 32'd0);
        repeat (3) cycle();
        chk("bus_error sticky", 32'(bus_error), 32'd1);

        // Reset in the middle of a store wait.
        do_reset("reset4");
        instruction = 32'h0020A023; imem_ready = 1'b1;
        cycle(); imem_ready = 1'b0;
        repeat (6) cycle();
        chk("midwait write_mem", 32'(write_mem), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwait reset outputs", {dut_sb(), bus_error, illegal_instr, state, instr_retired}, 32'd0);
        do_reset("reset5");

        if (TRAP) begin
            instruction = 32'h00000000; imem_ready = 1'b1;
            cycle(); imem_ready = 1'b0;
            cycle();
            chk("trap state", 32'(state), 32'd5);
            chk("trap illegal pulse", 32'(illegal_instr), 32'd1);
            cycle();
            chk("trap pulse ends", 32'(illegal_instr), 32'd0);
            chk("trap strobes", 32'(dut_sb()), 32'd0);
            repeat (3) cycle();
            chk("trap holds", {29'd0, state}, 32'd5);
            chk("trap no retire", 32'(instr_retired), 32'd0);
            do_reset("reset6");
            imem_ready = 1'b0;
            repeat (TIMEOUT) cycle();
            chk("fetch timeout trap", 32'(state), 32'd5);
            chk("fetch timeout berr", 32'(bus_error), 32'd1);
        end else begin
            instruction = 32'h002081B3;
            build_trace(32'h002081B3, 1'b0, 20, 0);
            play_trace("fetch retry");
            chk("fetch retry berr", 32'(bus_error), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
